// File: rtl/alu_issue_queue_pkg.sv
// Shared types and constants for the ALU issue queue and its register scoreboard.
//   REG_IDX_W / NUM_REGS : architectural register file geometry
//   alu_iq_src_t         : source-operand descriptor held per queue entry
//   alu_iq_entry_t       : full dispatcher->ALU entry at the default payload width
//   src_ready()          : one source operand is satisfied by the scoreboard
package alu_issue_queue_pkg;

  localparam int REG_IDX_W        = 5;
  localparam int NUM_REGS         = 32;
  localparam int ALU_IQ_PAYLOAD_W = 128;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     uses_rs1;
    logic     uses_rs2;
  } alu_iq_src_t;

  // Complete entry at the default width. The queue keeps sources and payload in
  // separate arrays so the payload width can stay a module parameter.
  typedef struct packed {
    alu_iq_src_t                 src;
    logic [ALU_IQ_PAYLOAD_W-1:0] payload;
  } alu_iq_entry_t;

  // x0 is hardwired zero, so it never waits on the scoreboard.
  function automatic logic src_ready(input logic uses, input reg_idx_t rs, input logic busy);
    return !uses || (rs == '0) || !busy;
  endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatcher / ALU / writeback bundle for alu_issue_queue.
//   master : dispatcher+ALU side (drives enq_*, branch_taken, sb_*)
//   slave  : the queue (drives enq_ready, issue_*, occupancy)
interface alu_issue_queue_if #(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = alu_issue_queue_pkg::ALU_IQ_PAYLOAD_W
);
  import alu_issue_queue_pkg::*;

  logic                   enq_valid;
  logic                   enq_ready;
  reg_idx_t               enq_rs1;
  reg_idx_t               enq_rs2;
  logic                   enq_uses_rs1;
  logic                   enq_uses_rs2;
  logic [PAYLOAD_W-1:0]   enq_payload;
  logic                   issue_valid;
  logic [PAYLOAD_W-1:0]   issue_payload;
  logic                   branch_taken;
  logic                   sb_set_valid;
  reg_idx_t               sb_set_rd;
  logic                   sb_clr_valid;
  reg_idx_t               sb_clr_rd;
  logic [$clog2(DEPTH):0] occupancy;

  modport master (
    output enq_valid, enq_rs1, enq_rs2, enq_uses_rs1, enq_uses_rs2, enq_payload,
    output branch_taken, sb_set_valid, sb_set_rd, sb_clr_valid, sb_clr_rd,
    input  enq_ready, issue_valid, issue_payload, occupancy
  );

  modport slave (
    input  enq_valid, enq_rs1, enq_rs2, enq_uses_rs1, enq_uses_rs2, enq_payload,
    input  branch_taken, sb_set_valid, sb_set_rd, sb_clr_valid, sb_clr_rd,
    output enq_ready, issue_valid, issue_payload, occupancy
  );

endinterface

// File: rtl/alu_issue_queue_reg_scoreboard.sv
// reg_scoreboard: busy bit per architectural register for pending long-latency
// writes. Registered set/clear, two combinational read ports.
//   clk, rst              : clock, async active-high reset (all bits free)
//   i_set_valid/i_set_rd  : mark destination busy (x0 ignored)
//   i_clr_valid/i_clr_rd  : mark destination free
//   i_rd_a/b -> o_busy_a/b: registered busy state, no same-cycle bypass
module reg_scoreboard
  import alu_issue_queue_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_set_valid,
  input  reg_idx_t i_set_rd,
  input  logic     i_clr_valid,
  input  reg_idx_t i_clr_rd,
  input  reg_idx_t i_rd_a,
  input  reg_idx_t i_rd_b,
  output logic     o_busy_a,
  output logic     o_busy_b
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Clear is applied first so a same-cycle set of the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_valid)
      w_busy_nxt[i_clr_rd] = 1'b0;
    if (i_set_valid && (i_set_rd != '0))
      w_busy_nxt[i_set_rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign o_busy_a = r_busy[i_rd_a];
  assign o_busy_b = r_busy[i_rd_b];

endmodule

// File: rtl/alu_issue_queue.sv
// alu_issue_queue: in-order issue queue in front of the ALU. Buffers decoded
// ops, holds the head until its sources are clear in the scoreboard, issues at
// most one op per cycle into a registered ALU slot, and drops everything when
// the op in the ALU slot resolves a taken branch.
//   clk, rst : clock, async active-high reset
//   bus      : alu_issue_queue_if.slave (enqueue handshake, issue slot,
//              branch_taken, scoreboard set/clear, occupancy)
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = ALU_IQ_PAYLOAD_W
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  alu_iq_src_t          r_src [DEPTH];
  logic [PAYLOAD_W-1:0] r_pay [DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_issue_valid;
  logic [PAYLOAD_W-1:0] r_issue_payload;

  alu_iq_src_t w_head;
  logic        w_flush;
  logic        w_enq_ready;
  logic        w_enq;
  logic        w_busy1;
  logic        w_busy2;
  logic        w_eligible;

  assign w_head      = r_src[r_rd_ptr];
  // A taken branch only counts when the ALU actually holds an op.
  assign w_flush     = bus.branch_taken && r_issue_valid;
  assign w_enq_ready = (r_count < CNT_W'(DEPTH)) && !w_flush;
  assign w_enq       = bus.enq_valid && w_enq_ready;

  reg_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_set_valid (bus.sb_set_valid),
    .i_set_rd    (bus.sb_set_rd),
    .i_clr_valid (bus.sb_clr_valid),
    .i_clr_rd    (bus.sb_clr_rd),
    .i_rd_a      (w_head.rs1),
    .i_rd_b      (w_head.rs2),
    .o_busy_a    (w_busy1),
    .o_busy_b    (w_busy2)
  );

  assign w_eligible = (r_count != '0) && !w_flush &&
                      src_ready(w_head.uses_rs1, w_head.rs1, w_busy1) &&
                      src_ready(w_head.uses_rs2, w_head.rs2, w_busy2);

  // Entry storage needs no reset: validity is carried entirely by r_count.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_src[r_wr_ptr] <= '{rs1:      bus.enq_rs1,
                            rs2:      bus.enq_rs2,
                            uses_rs1: bus.enq_uses_rs1,
                            uses_rs2: bus.enq_uses_rs2};
      r_pay[r_wr_ptr] <= bus.enq_payload;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr        <= '0;
      r_wr_ptr        <= '0;
      r_count         <= '0;
      r_issue_valid   <= 1'b0;
      r_issue_payload <= '0;
    end else if (w_flush) begin
      // Payload is left as-is; issue_valid low makes it don't-care.
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_issue_valid <= 1'b0;
    end else begin
      r_issue_valid <= w_eligible;
      if (w_eligible) begin
        r_issue_payload <= r_pay[r_rd_ptr];
        r_rd_ptr        <= r_rd_ptr + PTR_W'(1);
      end
      if (w_enq)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_eligible);
    end
  end

  assign bus.enq_ready     = w_enq_ready;
  assign bus.issue_valid   = r_issue_valid;
  assign bus.issue_payload = r_issue_payload;
  assign bus.occupancy     = r_count;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue. A queue-based reference model steps
// on each clock edge; one compare process checks the DUT against it every
// cycle and also checks hand-computed literal expectations ("pins").
module tb_alu_issue_queue;

  localparam int DEPTH = 4;
  localparam int PW    = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_issue_queue_if #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) bus ();

  alu_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    bit            u1;
    bit            u2;
    logic [PW-1:0] pay;
  } op_t;

  op_t           m_q[$];
  bit            m_busy[32];
  bit            m_iv  = 1'b0;
  logic [PW-1:0] m_pay = '0;

  function automatic bit src_ok(input bit u, input logic [4:0] r);
    return !u || r == 5'd0 || !m_busy[r];
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_iv  = 1'b0;
        m_pay = '0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
      end else begin
        bit  fl, rdy, el;
        op_t h;
        fl  = bus.branch_taken && m_iv;
        rdy = (m_q.size() < DEPTH) && !fl;
        el  = 1'b0;
        if (m_q.size() > 0 && !fl) begin
          h  = m_q[0];
          el = src_ok(h.u1, h.rs1) && src_ok(h.u2, h.rs2);
        end
        if (fl) begin
          m_q.delete();
          m_iv = 1'b0;
        end else begin
          m_iv = el;
          if (el) begin
            m_pay = h.pay;
            void'(m_q.pop_front());
          end
          if (bus.enq_valid && rdy)
            m_q.push_back('{bus.enq_rs1, bus.enq_rs2, bus.enq_uses_rs1,
                            bus.enq_uses_rs2, bus.enq_payload});
        end
        if (bus.sb_clr_valid) m_busy[bus.sb_clr_rd] = 1'b0;
        if (bus.sb_set_valid && bus.sb_set_rd != 5'd0) m_busy[bus.sb_set_rd] = 1'b1;
      end
    end
  end

  // ---------------- compare process ----------------
  int total = 0;
  int bad   = 0;

  // Literal expectation posted by the stimulus; -1 means don't care.
  int            pin_seq  = 0;
  int            pin_done = 0;
  string         pin_name = "";
  int            pin_iv   = -1;
  int            pin_occ  = -1;
  int            pin_rdy  = -1;
  bit            pin_cpay = 1'b0;
  logic [PW-1:0] pin_pay  = '0;

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or posedge rst);
      #1;
      if (pin_seq != pin_done) begin
        pin_done = pin_seq;
        if (pin_iv  >= 0) chk({pin_name, ".iv"},  PW'(bus.issue_valid), PW'(pin_iv));
        if (pin_occ >= 0) chk({pin_name, ".occ"}, PW'(bus.occupancy),   PW'(pin_occ));
        if (pin_rdy >= 0) chk({pin_name, ".rdy"}, PW'(bus.enq_ready),   PW'(pin_rdy));
        if (pin_cpay)     chk({pin_name, ".pay"}, bus.issue_payload,    pin_pay);
      end
      if (!rst) begin
        chk("model.iv",  PW'(bus.issue_valid), PW'(m_iv));
        chk("model.occ", PW'(bus.occupancy),   PW'(m_q.size()));
        chk("model.rdy", PW'(bus.enq_ready),
            PW'((m_q.size() < DEPTH) && !(bus.branch_taken && m_iv)));
        if (m_iv) chk("model.pay", bus.issue_payload, m_pay);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input int iv, input int occ, input int rdy,
                     input bit cpay, input logic [PW-1:0] pay);
    pin_name = nm; pin_iv = iv; pin_occ = occ; pin_rdy = rdy;
    pin_cpay = cpay; pin_pay = pay;
    pin_seq++;
  endtask

  task automatic enq(input logic [4:0] r1, input logic [4:0] r2, input bit u1,
                     input bit u2, input logic [PW-1:0] p);
    bus.enq_valid = 1'b1; bus.enq_rs1 = r1; bus.enq_rs2 = r2;
    bus.enq_uses_rs1 = u1; bus.enq_uses_rs2 = u2; bus.enq_payload = p;
  endtask

  task automatic sb_set(input logic [4:0] rd);
    bus.sb_set_valid = 1'b1; bus.sb_set_rd = rd;
  endtask

  task automatic sb_clr(input logic [4:0] rd);
    bus.sb_clr_valid = 1'b1; bus.sb_clr_rd = rd;
  endtask

  task automatic idle();
    bus.enq_valid = 1'b0; bus.sb_set_valid = 1'b0; bus.sb_clr_valid = 1'b0;
    bus.branch_taken = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    bus.enq_rs1 = '0; bus.enq_rs2 = '0; bus.enq_uses_rs1 = 1'b0;
    bus.enq_uses_rs2 = 1'b0; bus.enq_payload = '0;
    bus.sb_set_rd = '0; bus.sb_clr_rd = '0;
    pin("reset", 0, 0, -1, 1'b1, '0);
    @(negedge clk);
    #3 rst = 1'b0;
    step();

    // single op, free sources: accepted at E, issued after E+1
    enq(5'd3, 5'd4, 1, 1, 128'hA1);
    step(); idle();
    pin("t1_queued", 0, 1, 1, 1'b0, '0);
    step();
    pin("t1_issue", 1, 0, 1, 1'b1, 128'hA1);
    step();

    // blocked head, younger independent op waits behind it
    sb_set(5'd5);
    step(); idle();
    enq(5'd5, 5'd0, 1, 0, 128'hB0);
    step();
    enq(5'd6, 5'd0, 1, 1, 128'hC0);
    step(); idle();
    pin("t2_blocked", 0, 2, 1, 1'b0, '0);
    step();
    sb_clr(5'd5);
    step(); idle();
    pin("t2_no_bypass", 0, 2, 1, 1'b0, '0);
    step();
    pin("t2_B", 1, 1, 1, 1'b1, 128'hB0);
    step();
    pin("t2_C", 1, 0, 1, 1'b1, 128'hC0);
    step();

    // fill with a busy source, drop a 5th, then drain with overlap and wrap
    sb_set(5'd8);
    step(); idle();
    for (int i = 0; i < 4; i++) begin
      enq(5'd8, 5'd0, 1, 0, 128'hD0 + PW'(i));
      step();
    end
    enq(5'd1, 5'd0, 1, 0, 128'hD4);
    pin("t3_full", 0, 4, 0, 1'b0, '0);
    step();
    pin("t3_drop", 0, 4, 0, 1'b0, '0);
    sb_clr(5'd8);
    step();
    bus.sb_clr_valid = 1'b0;
    step();
    pin("t3_deq1", 1, 3, 1, 1'b1, 128'hD0);
    step();
    pin("t3_same", 1, 3, 1, 1'b1, 128'hD1);
    enq(5'd1, 5'd0, 1, 0, 128'hD5);
    step(); idle();
    pin("t3_same2", 1, 3, 1, 1'b1, 128'hD2);
    step();
    step();
    pin("t3_wrap4", 1, 1, 1, 1'b1, 128'hD4);
    step();
    pin("t3_wrap5", 1, 0, 1, 1'b1, 128'hD5);
    step();

    // taken branch with 3 entries queued behind the issued op
    sb_set(5'd7);
    step();
    sb_set(5'd10);
    step(); idle();
    enq(5'd10, 5'd0, 1, 0, 128'hE0);
    step();
    for (int i = 1; i < 4; i++) begin
      enq(5'd7, 5'd0, 1, 0, 128'hE0 + PW'(i));
      step();
    end
    idle();
    sb_clr(5'd10);
    step(); idle();
    pin("t4_queued", 0, 4, 0, 1'b0, '0);
    step();
    bus.branch_taken = 1'b1;
    enq(5'd1, 5'd0, 1, 0, 128'hE4);
    pin("t4_flush_cyc", 1, 3, 0, 1'b1, 128'hE0);
    step(); idle();
    pin("t4_after", 0, 0, 1, 1'b0, '0);
    enq(5'd7, 5'd0, 1, 0, 128'hF0);
    step(); idle();
    step();
    pin("t4_sb7_busy", 0, 1, 1, 1'b0, '0);
    bus.branch_taken = 1'b1;    // no op in the ALU: must not flush
    step(); idle();
    pin("t4_no_flush", 0, 1, 1, 1'b0, '0);
    sb_clr(5'd7);
    step(); idle();
    step();
    pin("t4_F", 1, 0, 1, 1'b1, 128'hF0);
    step();

    // same-cycle set+clear: set wins; x0 never busy
    sb_set(5'd9); sb_clr(5'd9);
    step(); idle();
    enq(5'd9, 5'd0, 1, 0, 128'h90);
    step(); idle();
    step();
    pin("t5_set_wins", 0, 1, 1, 1'b0, '0);
    sb_clr(5'd9);
    step(); idle();
    step();
    pin("t5_G", 1, 0, 1, 1'b1, 128'h90);
    sb_set(5'd0);
    step(); idle();
    enq(5'd0, 5'd0, 1, 1, 128'h70);
    step(); idle();
    step();
    pin("t5_x0", 1, 0, 1, 1'b1, 128'h70);
    step();

    // asynchronous reset with 2 entries queued and an op in the ALU slot
    sb_set(5'd11);
    step();
    sb_set(5'd12);
    step(); idle();
    enq(5'd12, 5'd0, 1, 0, 128'h60);
    step();
    enq(5'd11, 5'd0, 1, 0, 128'h61);
    step();
    enq(5'd11, 5'd0, 1, 0, 128'h62);
    step(); idle();
    sb_clr(5'd12);
    step(); idle();
    step();
    pin("t6_pre", 1, 2, 1, 1'b1, 128'h60);
    @(negedge clk);
    #3;
    pin("t6_async", 0, 0, -1, 1'b1, '0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    enq(5'd11, 5'd0, 1, 0, 128'h50);
    step(); idle();
    step();
    pin("t6_sb_clear", 1, 0, 1, 1'b1, 128'h50);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
